// File: rtl/mio_pkg.sv
// mio_pkg: address map, FSM state and region types for mio_responder.
// The timer regions decode as mapped only when the caller reports the timer.
package mio_pkg;

  localparam logic [31:0] MIO_LED_ADDR  = 32'hE000_0000;
  localparam logic [31:0] MIO_SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] MIO_RLD_ADDR  = 32'hF000_0004;
  localparam logic [31:0] MIO_STAT_ADDR = 32'hF000_0008;

  localparam int MIO_RAM_WAIT_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mio_state_e;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_LED,
    RG_SW,
    RG_RLD,
    RG_STAT
  } mio_region_e;

  // Word-address decode; byte-lane bits are not part of the map.
  function automatic mio_region_e mio_decode(
    input logic [29:0] wa,
    input int unsigned words,
    input bit          tmr
  );
    mio_region_e r;
    r = RG_NONE;
    if (wa < 30'(words))
      r = RG_RAM;
    else if (wa == MIO_LED_ADDR[31:2])
      r = RG_LED;
    else if (wa == MIO_SW_ADDR[31:2])
      r = RG_SW;
    else if (tmr && wa == MIO_RLD_ADDR[31:2])
      r = RG_RLD;
    else if (tmr && wa == MIO_STAT_ADDR[31:2])
      r = RG_STAT;
    return r;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// mio_timer: 32-bit reloading down counter with a sticky interrupt.
// Reload of zero halts counting; an expiry beats a same-cycle clear.
module mio_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rld_we_i,
  input  logic [31:0] rld_wdata_i,
  input  logic        stat_we_i,
  output logic [31:0] rld_o,
  output logic        int_o
);

  logic [31:0] rld_q;
  logic [31:0] cnt_q;
  logic        int_q;
  logic        expire;

  assign expire = !rld_we_i && (rld_q != '0) && (cnt_q == 32'd1);

  // Counter, reload register and sticky interrupt flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rld_q <= '0;
      cnt_q <= '0;
      int_q <= 1'b0;
    end else begin
      if (rld_we_i) begin
        rld_q <= rld_wdata_i;
        cnt_q <= rld_wdata_i;
      end else if (rld_q != '0) begin
        cnt_q <= expire ? rld_q : cnt_q - 32'd1;
      end
      if (expire)
        int_q <= 1'b1;
      else if (stat_we_i)
        int_q <= 1'b0;
    end
  end

  assign rld_o = rld_q;
  assign int_o = int_q;

endmodule

// File: rtl/mio_responder.sv
// mio_responder: CPU memory/IO responder with RAM, LEDs, switches, timer.
// Define MIO_TIMER_EN to include the timer, reload/status regs and INT.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_DEPTH = 64,
  parameter int RAM_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_bus,
  input  logic [31:0] Data_write,
  output logic [31:0] Data_read,
  output logic        MIO_ready,
  output logic        INT,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int RW = (RAM_WAIT > MIO_RAM_WAIT_MAX) ?
                      MIO_RAM_WAIT_MAX : RAM_WAIT;
  localparam bit HAS_WAIT = (RW > 0);
  localparam logic [2:0] WAIT_LAST = 3'(RW - 1);
`ifdef MIO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  mio_state_e  state_q;
  logic [2:0]  wcnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [15:0] led_q;
  logic [31:0] mem [RAM_DEPTH];

  logic [31:0] addr_d;
  mio_region_e dec_in;
  mio_region_e dec_d;
  mio_region_e dec_q;
  logic [31:0] rd_val;
  logic        commit;
  logic [31:0] tmr_rld;
  logic        tmr_int;
  logic        unused_ab;

  assign unused_ab = ^{Addr_bus[1:0], addr_q[1:0]};

  // Read data is formed from the live bus on acceptance, else the latch.
  assign addr_d = (state_q == ST_IDLE) ? Addr_bus : addr_q;
  assign dec_in = mio_decode(Addr_bus[31:2], RAM_DEPTH, TIMER_EN);
  assign dec_d  = mio_decode(addr_d[31:2], RAM_DEPTH, TIMER_EN);
  assign dec_q  = mio_decode(addr_q[31:2], RAM_DEPTH, TIMER_EN);
  assign commit = (state_q == ST_RESP) && we_q;

  // Read mux for whichever target is about to respond.
  always_comb begin
    rd_val = '0;
    unique case (dec_d)
      RG_RAM:  rd_val = mem[addr_d[AW+1:2]];
      RG_LED:  rd_val = {16'h0, led_q};
      RG_SW:   rd_val = {16'h0, sw};
      RG_RLD:  rd_val = tmr_rld;
      RG_STAT: rd_val = {31'h0, tmr_int};
      default: rd_val = '0;
    endcase
  end

  // Transaction FSM with registered ready pulse and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (CPU_MIO) begin
            addr_q  <= Addr_bus;
            wdata_q <= Data_write;
            we_q    <= mem_w;
            if (dec_in == RG_RAM && HAS_WAIT) begin
              state_q <= ST_WAIT;
              wcnt_q  <= '0;
            end else begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              rdata_q <= mem_w ? '0 : rd_val;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            wcnt_q  <= '0;
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= we_q ? '0 : rd_val;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && commit && dec_q == RG_RAM)
      mem[addr_q[AW+1:2]] <= wdata_q;
  end

  // LED output register.
  always_ff @(posedge clk) begin
    if (!reset)
      led_q <= '0;
    else if (commit && dec_q == RG_LED)
      led_q <= wdata_q[15:0];
  end

`ifdef MIO_TIMER_EN
  logic rld_we;
  logic stat_we;

  assign rld_we  = commit && dec_q == RG_RLD;
  assign stat_we = commit && dec_q == RG_STAT;

  mio_timer u_timer (
    .clk_i       (clk),
    .rst_ni      (reset),
    .rld_we_i    (rld_we),
    .rld_wdata_i (wdata_q),
    .stat_we_i   (stat_we),
    .rld_o       (tmr_rld),
    .int_o       (tmr_int)
  );
`else
  assign tmr_rld = '0;
  assign tmr_int = 1'b0;
`endif

  assign Data_read = rdata_q;
  assign MIO_ready = ready_q;
  assign INT       = tmr_int;
  assign led       = led_q;

endmodule

// File: tb/tb_mio_responder.sv
// tb_mio_responder: randomized bus traffic checked against a reference
// model of the memory map, latencies and timer expiry schedule.
module tb_mio_responder;

  localparam int RAM_DEPTH = 64;
  localparam int RAM_WAIT  = 2;
`ifdef MIO_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] Addr_bus;
  logic [31:0] Data_write;
  logic [31:0] Data_read;
  logic        MIO_ready;
  logic        INT;
  logic [15:0] sw;
  logic [15:0] led;

  mio_responder #(
    .RAM_DEPTH (RAM_DEPTH),
    .RAM_WAIT  (RAM_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .CPU_MIO    (CPU_MIO),
    .mem_w      (mem_w),
    .Addr_bus   (Addr_bus),
    .Data_write (Data_write),
    .Data_read  (Data_read),
    .MIO_ready  (MIO_ready),
    .INT        (INT),
    .sw         (sw),
    .led        (led)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  bit in_xact = 1'b0;

  // reference state
  logic [31:0] mem_m [RAM_DEPTH];
  logic [15:0] led_m = '0;
  int t_load = 0;
  int t_rel = 0;
  int prev_set = -1;
  int last_clr = -1;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, got, exp, edge_n);
    end
  endfunction

  // 0 none, 1 ram, 2 led, 3 sw, 4 reload, 5 status
  function automatic int region(logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'(RAM_DEPTH * 4)) return 1;
    if (w == 32'hE000_0000) return 2;
    if (w == 32'hF000_0000) return 3;
    if (TEN && w == 32'hF000_0004) return 4;
    if (TEN && w == 32'hF000_0008) return 5;
    return 0;
  endfunction

  // latest expiry edge of the current reload epoch, or -1
  function automatic int last_exp(int now);
    if (t_rel == 0 || now < t_load + t_rel) return -1;
    return t_load + ((now - t_load) / t_rel) * t_rel;
  endfunction

  function automatic bit model_int(int now);
    int s;
    s = last_exp(now);
    if (prev_set > s) s = prev_set;
    return (s >= 0) && (s >= last_clr);
  endfunction

  function automatic logic [31:0] model_rd(logic [31:0] a, int re);
    case (region(a))
      1: return mem_m[a[7:2]];
      2: return {16'h0, led_m};
      3: return {16'h0, sw};
      4: return 32'(t_rel);
      5: return {31'h0, model_int(re - 1)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_wr(logic [31:0] a, logic [31:0] d, int c);
    int e;
    case (region(a))
      1: mem_m[a[7:2]] = d;
      2: led_m = d[15:0];
      4: begin
        e = last_exp(c - 1);
        if (e > prev_set) prev_set = e;
        t_load = c;
        t_rel = int'(d);
      end
      5: last_clr = c;
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    led_m = '0;
    t_rel = 0;
    t_load = 0;
    prev_set = -1;
    last_clr = -1;
  endfunction

  // Per-cycle compare of the free-running outputs.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("int", {31'h0, INT}, {31'h0, model_int(edge_n)});
      chk("led", {16'h0, led}, {16'h0, led_m});
      if (MIO_ready !== 1'b1)
        chk("rdata_idle", Data_read, 32'h0);
      if (!in_xact)
        chk("spurious_ready", {31'h0, MIO_ready}, 32'h0);
    end
  end

  task automatic xact(input bit w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output int ce);
    int k;
    int re;
    int lat;
    logic [31:0] er;
    @(negedge clk);
    CPU_MIO = 1'b1;
    mem_w = w;
    Addr_bus = a;
    Data_write = d;
    in_xact = 1'b1;
    k = edge_n;
    re = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (MIO_ready === 1'b1) begin
        re = edge_n;
        break;
      end
      Addr_bus = $urandom;
      Data_write = $urandom;
      mem_w = 1'($urandom_range(0, 1));
    end
    rd = Data_read;
    CPU_MIO = 1'b0;
    mem_w = 1'b0;
    lat = (region(a) == 1) ? RAM_WAIT + 1 : 1;
    if (re < 0) begin
      chk("ready_timeout", 32'h0, 32'h1);
      in_xact = 1'b0;
      ce = edge_n + 1;
    end else begin
      chk("latency", 32'(re - k), 32'(lat));
      er = w ? 32'h0 : model_rd(a, re);
      chk(w ? "wr_data" : "rd_data", rd, er);
      @(posedge clk);
      in_xact = 1'b0;
      ce = re + 1;
      if (w) model_wr(a, d, ce);
    end
  endtask

  task automatic wait_edge(input int tgt);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (edge_n < tgt && g < 500);
    chk("wait_edge", 32'(edge_n), 32'(tgt));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    int ce;
    int r;
    int tw;
    int seen;
    int x;

    // reset with a competing write to the LED register
    reset = 1'b0;
    CPU_MIO = 1'b1;
    mem_w = 1'b1;
    Addr_bus = 32'hE000_0000;
    Data_write = 32'h0000_FFFF;
    sw = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
    chk("rst_rdata", Data_read, 32'h0);
    chk("rst_int", {31'h0, INT}, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    CPU_MIO = 1'b0;
    mem_w = 1'b0;
    reset = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i < RAM_DEPTH; i++)
      xact(1'b1, 32'(i * 4), $urandom, rd, ce);

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, rd, ce);
    xact(1'b0, 32'h10, 32'h0, rd, ce);
    chk("ram_lit", rd, 32'hDEAD_BEEF);

    sw = 16'h00A5;
    xact(1'b0, 32'hF000_0000, 32'h0, rd, ce);
    chk("sw_lit", rd, 32'h0000_00A5);
    xact(1'b1, 32'hE000_0000, 32'h0000_1234, rd, ce);
    @(negedge clk);
    chk("led_lit", {16'h0, led}, 32'h0000_1234);

    xact(1'b0, 32'h8000_0000, 32'h0, rd, ce);
    chk("unmapped_rd", rd, 32'h0);
    xact(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rd, ce);
    xact(1'b0, 32'h10, 32'h0, rd, ce);
    chk("unmapped_wr_ram", rd, 32'hDEAD_BEEF);

`ifdef MIO_TIMER_EN
    xact(1'b1, 32'hF000_0004, 32'd5, rd, ce);
    tw = ce;
    seen = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (INT === 1'b1) begin
        seen = edge_n;
        break;
      end
    end
    chk("int_delay", 32'(seen - tw), 32'd5);
    xact(1'b1, 32'hF000_0008, 32'h0, rd, ce);
    @(negedge clk);
    chk("int_clear", {31'h0, INT}, 32'h0);
    x = tw + 5 * ((ce + 4 - tw + 4) / 5);
    wait_edge(x - 3);
    xact(1'b1, 32'hF000_0008, 32'h0, rd, ce);
    chk("coincide_edge", 32'(ce), 32'(x));
    @(negedge clk);
    chk("set_wins", {31'h0, INT}, 32'h1);
    xact(1'b0, 32'hF000_0008, 32'h0, rd, ce);
    chk("stat_rd", rd, 32'h1);
    xact(1'b1, 32'hF000_0004, 32'd0, rd, ce);
    xact(1'b1, 32'hF000_0008, 32'h0, rd, ce);
    repeat (20) @(negedge clk);
    chk("halted", {31'h0, INT}, 32'h0);
`else
    xact(1'b1, 32'hF000_0004, 32'd3, rd, ce);
    xact(1'b0, 32'hF000_0004, 32'h0, rd, ce);
    chk("no_tmr_rd", rd, 32'h0);
    repeat (10) @(negedge clk);
    chk("no_tmr_int", {31'h0, INT}, 32'h0);
`endif

    // reset lands in WAIT of a write to 0x20, request held high
    @(negedge clk);
    CPU_MIO = 1'b1;
    mem_w = 1'b1;
    Addr_bus = 32'h20;
    Data_write = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ready", {31'h0, MIO_ready}, 32'h0);
    end
    reset = 1'b1;
    CPU_MIO = 1'b0;
    mem_w = 1'b0;
    xact(1'b0, 32'h20, 32'h0, rd, ce);
    chk("rst_keep", rd, mem_m[8]);

    for (int i = 0; i < 80; i++) begin
      sw = 16'($urandom);
      r = $urandom_range(0, 5);
      d = $urandom;
      case (r)
        0: a = 32'($urandom_range(0, RAM_DEPTH * 4 - 1));
        1: a = 32'hE000_0000 | 32'($urandom_range(0, 3));
        2: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        3: begin
          a = 32'hF000_0004 | 32'($urandom_range(0, 3));
          d = 32'($urandom_range(0, 9));
        end
        4: a = 32'hF000_0008;
        default: a = 32'h8000_0000 + 32'($urandom_range(0, 255) * 4);
      endcase
      xact(1'($urandom_range(0, 1)), a, d, rd, ce);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 64, data RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter RAM_WAIT, default 2, number of wait cycles for a RAM access (range 0..7).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port CPU_MIO  input  1  request strobe from the CPU, held until MIO_ready.
REQ-006 SHALL have port mem_w  input  1  1 = write, 0 = read; qualified by CPU_MIO.
REQ-007 SHALL have port Addr_bus  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port Data_write  input  32  write data.
REQ-009 SHALL have port Data_read  output  32  read data; valid only while MIO_ready=1.
REQ-010 SHALL have port MIO_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port INT  output  1  timer interrupt request, level, sticky.
REQ-012 SHALL have port sw  input  16  switch inputs.
REQ-013 SHALL have port led  output  16  LED output register.

Function
REQ-014 SHALL decode the address map: 0x0000_0000..RAM_DEPTH*4-1 RAM; 0xE000_0000 LED register (R/W, bits[15:0]); 0xF000_0000 switches (RO, zero-extended); 0xF000_0004 timer reload (R/W); 0xF000_0008 timer status (read bit0 = INT; any write clears INT).
REQ-015 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; IDLE samples CPU_MIO each cycle.
REQ-016 SHALL go from IDLE to WAIT for a RAM access with RAM_WAIT>0, otherwise directly to RESP.
REQ-017 SHALL stay in WAIT for exactly RAM_WAIT cycles, counted by a 3-bit counter, then go to RESP.
REQ-018 SHALL assert MIO_ready for exactly one cycle in RESP; register accesses complete with MIO_ready one cycle after acceptance; RAM accesses complete RAM_WAIT+1 cycles after acceptance.
REQ-019 SHALL latch address, data and mem_w at acceptance; later changes on the inputs during WAIT are ignored.
REQ-020 SHALL commit writes (RAM or register) in the RESP cycle and drive Data_read=0 during write responses.
REQ-021 SHALL drive Data_read=0 whenever MIO_ready=0.
REQ-022 SHALL complete unmapped accesses as register accesses: reads return 0, writes are dropped.
REQ-023 SHALL accept the next request no earlier than the cycle after RESP (back-to-back throughput is one access per RAM_WAIT+2 cycles).
REQ-024 SHALL run the timer as a 32-bit down counter: it loads reload when it reaches 1, sets INT on that cycle, and reload=0 halts the counter.
REQ-025 SHALL also load the counter immediately from the new value when the reload register is written.
REQ-026 SHALL let set win over clear when an expiry and a status write occur in the same cycle, leaving INT=1.

Reset
REQ-027 SHALL, on reset=0 at a clock edge, force FSM=IDLE, MIO_ready=0, Data_read=0, INT=0, led=0, reload=0, counter=0 and the wait counter to 0.
REQ-028 SHALL abandon an in-flight transaction on reset without committing its write; RAM contents are not cleared.
REQ-029 SHALL keep reset dominant over a simultaneous CPU_MIO request.

Configuration
REQ-030 SHALL, with MIO_TIMER_EN defined, include the timer, reload and status registers and the INT logic.
REQ-031 SHALL, without MIO_TIMER_EN, tie INT to 0, treat 0xF000_0004 and 0xF000_0008 as unmapped, and omit the timer logic.

Structure
REQ-032 SHALL place the address-map constants, the FSM state typedef and the RAM_WAIT limit in the shared package mio_pkg.
REQ-033 SHALL implement the timer as the sub-module mio_timer, instantiated only under MIO_TIMER_EN.

Verification
REQ-034 SHALL verify: write 0xDEADBEEF to 0x10, then read 0x10 with RAM_WAIT=2 -> MIO_ready 3 cycles after each acceptance and read Data_read=0xDEADBEEF.
REQ-035 SHALL verify: sw=0x00A5, read 0xF000_0000 -> Data_read=0x0000_00A5 one cycle after acceptance; write 0x1234 to 0xE000_0000 -> led=0x1234.
REQ-036 SHALL verify: reload=5 -> INT rises 5 cycles after the write; a status write clears INT; an expiry coinciding with the status write leaves INT=1.
REQ-037 SHALL verify: reset=0 asserted during WAIT of a write to 0x20 -> no MIO_ready, and 0x20 keeps its old value.
REQ-038 SHALL verify: read 0x8000_0000 -> Data_read=0 with MIO_ready; a write to 0x8000_0000 changes no state.
REQ-039 SHALL verify: build without MIO_TIMER_EN, write 3 to 0xF000_0004 -> INT stays 0 and reading 0xF000_0004 returns 0.
